// File: rtl/jtframe_romload_pkg.sv
// Shared types and constants for the ROM-download-to-SDRAM bridge.
package jtframe_romload_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] MASK_LO_WR = 2'b10;
  localparam logic [1:0] MASK_HI_WR = 2'b01;
  localparam logic [1:0] MASK_NONE  = 2'b11;

  // Entry layout is {word address, odd-byte flag, byte}.
  function automatic int entry_w(input int aw);
    return aw + 1 + 8;
  endfunction

endpackage

// File: rtl/jtframe_romload_fifo.sv
// Small synchronous FIFO; reads fall through when empty so a push and pop
// in the same cycle hand the incoming word straight to the consumer.
module jtframe_romload_fifo #(
  parameter int W  = 31,
  parameter int AW = 2
)(
  input  logic         clk_rom,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push_s, do_pop_s;

  // flags, effective push/pop and next pointers
  always_comb begin
    empty     = (cnt_q == (AW+1)'(0));
    full      = (cnt_q == (AW+1)'(DEPTH));
    do_push_s = push && (!full || pop);
    do_pop_s  = pop && (!empty || push);
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
    dout = empty ? din : mem_q[rd_ptr_q];
  end

  // storage array
  always_ff @(posedge clk_rom) begin
    if (do_push_s) mem_q[wr_ptr_q] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      cnt_q    <= (AW+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/jtframe_romload_sdram.sv
// Turns the data_io byte stream into masked 16-bit SDRAM programming writes,
// buffering bytes so controller stalls do not lose data.
module jtframe_romload_sdram
  import jtframe_romload_pkg::*;
#(
  parameter int HEADER  = 0,
  parameter int FIFO_AW = 2,
  parameter int AW      = 22
)(
  input  logic          clk_rom,
  input  logic          rst,
  input  logic          downloading,
  input  logic [22:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_ack,
  output logic          dwnld_busy,
  output logic          dwnld_done,
  output logic          overflow,
  output logic [22:0]   byte_cnt
);
  localparam int          EW  = entry_w(AW);
  localparam logic [22:0] HDR = 23'(HEADER);

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic          downloading_q, downloading_d;
  logic [AW-1:0] prog_addr_q, prog_addr_d;
  logic [15:0]   prog_data_q, prog_data_d;
  logic [1:0]    prog_mask_q, prog_mask_d;
  logic          prog_we_q, prog_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic [22:0]   byte_cnt_q, byte_cnt_d;

  logic [22:0]   rel_s;
  logic          accept_s, issue_s, drop_s, rise_s;
  logic [EW-1:0] push_entry_s, fifo_dout_s;
  logic          fifo_full_s, fifo_empty_s;

  // byte acceptance and issue decisions
  always_comb begin
    rel_s        = ioctl_addr - HDR;
    accept_s     = ioctl_wr && (state_q == ACTIVE) && (ioctl_addr >= HDR);
    push_entry_s = {AW'(rel_s >> 1), rel_s[0], ioctl_data};
    // an idle output stage takes the FIFO head, or the incoming byte if empty
    issue_s      = !prog_we_q && (!fifo_empty_s || accept_s);
    drop_s       = accept_s && fifo_full_s && !issue_s;
    rise_s       = downloading && !downloading_q;
  end

  jtframe_romload_fifo #(
    .W  (EW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_rom (clk_rom),
    .rst     (rst),
    .push    (accept_s && !drop_s),
    .din     (push_entry_s),
    .pop     (issue_s),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // next state for the request stage and download sequencing
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    downloading_d = downloading;
    prog_addr_d   = prog_addr_q;
    prog_data_d   = prog_data_q;
    prog_mask_d   = prog_mask_q;
    prog_we_d     = prog_we_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q;
    byte_cnt_d    = byte_cnt_q;

    if (prog_we_q && prog_ack) begin
      prog_we_d = 1'b0;
    end else if (issue_s) begin
      prog_we_d   = 1'b1;
      prog_addr_d = fifo_dout_s[EW-1:9];
      prog_data_d = {fifo_dout_s[7:0], fifo_dout_s[7:0]};
      prog_mask_d = fifo_dout_s[8] ? MASK_HI_WR : MASK_LO_WR;
    end else begin
      prog_we_d = prog_we_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (accept_s) begin
      byte_cnt_d = byte_cnt_q + 23'd1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (rise_s || pending_q) begin
          state_d    = ACTIVE;
          pending_d  = 1'b0;
          busy_d     = 1'b1;
          byte_cnt_d = 23'd0;
          overflow_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!downloading) begin
          state_d = FLUSH;
        end else begin
          state_d = ACTIVE;
        end
      end
      FLUSH: begin
        pending_d = pending_q || rise_s;
        // the last acknowledge empties the pipe in this very cycle
        if (fifo_empty_s && (!prog_we_q || prog_ack)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE: begin
        pending_d = pending_q || rise_s;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      downloading_q <= 1'b0;
      prog_addr_q   <= AW'(0);
      prog_data_q   <= 16'd0;
      prog_mask_q   <= MASK_NONE;
      prog_we_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      byte_cnt_q    <= 23'd0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      downloading_q <= downloading_d;
      prog_addr_q   <= prog_addr_d;
      prog_data_q   <= prog_data_d;
      prog_mask_q   <= prog_mask_d;
      prog_we_q     <= prog_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      byte_cnt_q    <= byte_cnt_d;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign dwnld_busy = busy_q;
  assign dwnld_done = done_q;
  assign overflow   = overflow_q;
  assign byte_cnt   = byte_cnt_q;

endmodule
